// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift-function encodings and the shift sequencer state encoding.
package alu_pkg;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_ROR = 2'b10;
   localparam logic [1:0] SH_SRA = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Request/result bundle of the iterative shifter; master drives requests, slave returns results.
interface shift_seq_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) ();
   logic             start;
   logic [1:0]       ALUfun;
   logic [WIDTH-1:0] B;
   logic [SHW-1:0]   shamt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] y;

   modport master (output start, ALUfun, B, shamt, input busy, done, y);
   modport slave  (input start, ALUfun, B, shamt, output busy, done, y);
endinterface

// File: rtl/shift_stage.sv
// Combinational single-stage shifter: shifts data by 2^sel using the given shift function.
module shift_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [1:0]       i_op,
   input  logic [SHW-1:0]   i_sel,
   output logic [WIDTH-1:0] o_data
);

   logic [SHW:0] w_s;
   logic [SHW:0] w_rs;

   assign w_s  = {{SHW{1'b0}}, 1'b1} << i_sel;
   assign w_rs = (SHW+1)'(WIDTH) - w_s;

   // Apply one 2^k step; rotate combines both directions so wrapped bits reappear at the MSB end.
   always_comb begin
      o_data = i_data;
      case (i_op)
         SH_SLL:  o_data = i_data << w_s;
         SH_SRL:  o_data = i_data >> w_s;
         SH_SRA:  o_data = $unsigned($signed(i_data) >>> w_s);
         SH_ROR:  o_data = (i_data >> w_s) | (i_data << w_rs);
         default: o_data = i_data;
      endcase
   end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one 2^k stage per clock (k = SHW-1 down to 0), reusing a single shift_stage.
module shift_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   shift_seq_if.slave  bus
);

   state_t           r_state;
   logic [WIDTH-1:0] r_work;
   logic [1:0]       r_op;
   logic [SHW-1:0]   r_amt;
   logic [SHW-1:0]   r_k;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] w_shifted;

   shift_stage #(.WIDTH(WIDTH), .SHW(SHW)) u_stage (
      .i_data (r_work),
      .i_op   (r_op),
      .i_sel  (r_k),
      .o_data (w_shifted)
   );

   // Sequencer FSM with registered busy/done/y; DONE accepts a new start like IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_work  <= '0;
         r_op    <= 2'b00;
         r_amt   <= '0;
         r_k     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_y     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  r_work <= bus.B;
                  r_op   <= bus.ALUfun;
                  r_amt  <= bus.shamt;
                  if (bus.shamt != '0) begin
                     r_state <= ST_SHIFT;
                     r_k     <= SHW'(SHW-1);
                     r_busy  <= 1'b1;
                  end else begin
                     r_y     <= bus.B;
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (r_amt[r_k]) begin
                  r_work <= w_shifted;
               end else begin
                  r_work <= r_work;
               end
               // Final stage: forward this cycle's stage output straight into y.
               if (r_k == '0) begin
                  r_y     <= r_amt[0] ? w_shifted : r_work;
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_k <= r_k - SHW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.y    = r_y;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: vector table plus hand-written multi-cycle corner sequences.
module tb_shift_seq;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   shift_seq_if #(.WIDTH(32), .SHW(5)) bus ();

   shift_seq #(.WIDTH(32), .SHW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] b;
      logic [4:0]  amt;
      logic [31:0] exp_y;
      int          exp_lat;
      string       name;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] b, input logic [4:0] amt,
                         input logic [31:0] ey, input int elat, input string nm);
      int lat;
      int nbusy;
      int novl;
      bit got;
      lat = 0; nbusy = 0; novl = 0; got = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.ALUfun = op; bus.B = b; bus.shamt = amt;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.ALUfun = ~op; bus.B = ~b; bus.shamt = ~amt;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (bus.busy && bus.done) novl++;
         if (bus.busy) nbusy++;
         if (bus.done) begin
            got = 1'b1;
            lat = i;
            check({nm, " y"}, bus.y, ey);
         end
      end
      check({nm, " latency"}, 32'(lat), 32'(elat));
      check({nm, " busy cycles"}, 32'(nbusy), 32'(elat - 1));
      check({nm, " busy&done"}, 32'(novl), 32'd0);
      @(negedge clk);
      check({nm, " done drop"}, {31'd0, bus.done}, 32'd0);
      check({nm, " y hold"}, bus.y, ey);
   endtask

   initial begin
      int nd;
      n_cmp = 0;
      n_err = 0;
      vecs[0]  = '{SH_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 6, "sll1_31"};
      vecs[1]  = '{SH_SRA, 32'hF000_0000, 5'd4,  32'hFF00_0000, 6, "sra_f_4"};
      vecs[2]  = '{SH_SRL, 32'hF000_0000, 5'd4,  32'h0F00_0000, 6, "srl_f_4"};
      vecs[3]  = '{SH_SLL, 32'hF000_0000, 5'd4,  32'h0000_0000, 6, "sll_f_4"};
      vecs[4]  = '{SH_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 6, "ror_8"};
      vecs[5]  = '{SH_ROR, 32'h8000_0001, 5'd1,  32'hC000_0000, 6, "ror_1"};
      vecs[6]  = '{SH_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, "srl_0"};
      vecs[7]  = '{SH_SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, "sra_0"};
      vecs[8]  = '{SH_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6, "sra_31"};
      vecs[9]  = '{SH_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 6, "srl_31"};
      vecs[10] = '{SH_ROR, 32'h0000_0001, 5'd31, 32'h0000_0002, 6, "ror_31"};
      vecs[11] = '{SH_SLL, 32'h1234_5678, 5'd16, 32'h5678_0000, 6, "sll_16"};
      vecs[12] = '{SH_ROR, 32'h1234_5678, 5'd21, 32'hA2B3_C091, 6, "ror_21"};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.ALUfun = 2'b00; bus.B = 32'h0; bus.shamt = 5'd0;
      #12;
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset y", bus.y, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].op, vecs[i].b, vecs[i].amt, vecs[i].exp_y, vecs[i].exp_lat, vecs[i].name);
      end

      // Second start while busy must be ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.ALUfun = SH_SLL; bus.B = 32'h1; bus.shamt = 5'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.ALUfun = SH_SRA; bus.B = 32'hFFFF_FFFF; bus.shamt = 5'd0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      nd = 0;
      for (int i = 0; i < 20 && nd == 0; i++) begin
         @(negedge clk);
         if (bus.done) nd = i + 2;
      end
      check("ignore latency", 32'(nd), 32'd6);
      check("ignore y", bus.y, 32'h0000_0008);

      // Back-to-back start during the DONE cycle.
      @(negedge clk);
      bus.start = 1'b1; bus.ALUfun = SH_SLL; bus.B = 32'h1; bus.shamt = 5'd2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      nd = 0;
      for (int i = 0; i < 20 && nd == 0; i++) begin
         @(negedge clk);
         if (bus.done) nd = 1;
      end
      check("b2b first done", 32'(nd), 32'd1);
      check("b2b first y", bus.y, 32'h0000_0004);
      bus.start = 1'b1; bus.ALUfun = SH_SRA; bus.B = 32'h8000_0000; bus.shamt = 5'd31;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("b2b done drop", {31'd0, bus.done}, 32'd0);
      check("b2b busy", {31'd0, bus.busy}, 32'd1);
      nd = 0;
      for (int i = 0; i < 20 && nd == 0; i++) begin
         @(negedge clk);
         if (bus.done) nd = i + 2;
      end
      check("b2b latency", 32'(nd), 32'd6);
      check("b2b y", bus.y, 32'hFFFF_FFFF);

      // Asynchronous reset in the third SHIFT cycle aborts the operation.
      @(negedge clk);
      bus.start = 1'b1; bus.ALUfun = SH_SLL; bus.B = 32'h1; bus.shamt = 5'd31;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre-abort busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort busy", {31'd0, bus.busy}, 32'd0);
      check("abort done", {31'd0, bus.done}, 32'd0);
      check("abort y", bus.y, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      check("no done after abort", 32'(nd), 32'd0);
      check("y after abort", bus.y, 32'd0);
      run_op(SH_SRL, 32'hF000_0000, 5'd4, 32'h0F00_0000, 6, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
